// File: rtl/dmem_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_param
// Function : fixed-latency data memory (IDLE->BUSY->RESP) with range/alignment
//            faults; macro DMEM_SUBWORD_EN enables byte/half accesses.
// Revision : 1.0
// ============================================================================
module dmem_param #(
  parameter int          DEPTH_WORDS = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  input  logic [31:0] address_in,
  input  logic [31:0] writeData_in,
  output logic        ready_out,
  output logic        done_out,
  output logic        err_out,
  output logic [31:0] data_out
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word;
  logic [31:0]      ld_data;
  logic             size_fault;
  logic             align_fault;
  logic             fault;
  logic             commit;

  // Decode uses only captured fields, so it is stable for the whole access.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && (offset < MEM_BYTES);
    idx      = offset[IDX_W+1:2];
    rd_word  = mem_q[idx];
  end

`ifdef DMEM_SUBWORD_EN
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = rd_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    size_fault  = 1'b0;
    align_fault = 1'b0;
    wr_word     = rd_word;
    ld_data     = rd_word;
    case (size_q)
      2'b00: begin
        wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        ld_data = {{24{signed_q & lane_b[7]}}, lane_b};
      end
      2'b01: begin
        align_fault = addr_q[0];
        wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        ld_data = {{16{signed_q & lane_h[15]}}, lane_h};
      end
      2'b10: begin
        align_fault = (addr_q[1:0] != 2'b00);
        wr_word     = wdata_q;
      end
      default: size_fault = 1'b1;
    endcase
  end
`else
  logic unused_signed;

  assign unused_signed = signed_q;

  always_comb begin
    size_fault  = (size_q != 2'b10);
    align_fault = (addr_q[1:0] != 2'b00);
    wr_word     = wdata_q;
    ld_data     = rd_word;
  end
`endif

  assign fault = !in_range || size_fault || align_fault;

  // Store lands on the BUSY->RESP edge; a reset on that edge aborts it.
  assign commit = (state_q == ST_BUSY) && (cnt_q == 4'd1) && we_q && !fault && !reset_in;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = err_q;
    data_d   = data_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          we_d     = we_in;
          size_d   = size_in;
          signed_d = signed_in;
          addr_d   = address_in;
          wdata_d  = writeData_in;
          cnt_d    = LAT_LOAD;
          state_d  = ST_BUSY;
          ready_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
          done_d  = 1'b1;
          err_d   = fault;
          data_d  = (fault || we_q) ? 32'd0 : ld_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= 32'd0;
      we_q     <= 1'b0;
      size_q   <= 2'b10;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      data_q   <= data_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[idx] <= wr_word;
    end
  end

  assign ready_out = ready_q;
  assign done_out  = done_q;
  assign err_out   = err_q;
  assign data_out  = data_q;

endmodule
`default_nettype wire

// File: doc/dmem_param.md
DMEM_PARAM -- requirements
Module: dmem_param

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 32, number of 32-bit words stored; power of two, 4..4096.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10000000, byte address of word 0; word-aligned.
REQ-003 SHALL have parameter LATENCY, default 2, number of BUSY cycles per access; 1..15.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_in, input, 1, access request.
REQ-007 SHALL have port we_in, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port size_in, input, 2, 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-009 SHALL have port signed_in, input, 1, sign-extend sub-word loads.
REQ-010 SHALL have port address_in, input, 32, byte address.
REQ-011 SHALL have port writeData_in, input, 32, store data, right-justified for sub-word stores.
REQ-012 SHALL have port ready_out, output, 1, high when a request can be accepted.
REQ-013 SHALL have port done_out, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port err_out, output, 1, completed access faulted; valid with done_out.
REQ-015 SHALL have port data_out, output, 32, load result; valid with done_out, held until the next accept.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; ready_out = (state == IDLE).
REQ-017 SHALL accept a request on an edge where req_in && ready_out, and capture we_in, size_in, signed_in, address_in and writeData_in in that cycle.
REQ-018 SHALL ignore req_in while not in IDLE; captured fields SHALL NOT change during BUSY.
REQ-019 SHALL stay in BUSY for exactly LATENCY cycles, using a down-counter loaded at accept, then enter RESP.
REQ-020 SHALL assert done_out only in RESP, for one cycle; accept-to-accept minimum is LATENCY+2 cycles.
REQ-021 SHALL commit a store at the BUSY->RESP edge, so a load accepted after that edge returns the new data.
REQ-022 SHALL compute offset = address_in - BASE_ADDR; in range iff address_in >= BASE_ADDR and offset < 4*DEPTH_WORDS; word index = offset[log2(DEPTH_WORDS)+1:2].
REQ-023 SHALL flag a fault when the address is out of range, size_in == 11, a half access has address_in[0] = 1, or a word access has address_in[1:0] != 0.
REQ-024 SHALL, on fault, perform no memory write, drive data_out = 0 and assert err_out with done_out.
REQ-025 SHALL use little-endian byte lanes: address bits [1:0] = 0 select bits [7:0]; half lane 0 is [15:0], half lane 2 is [31:16].
REQ-026 SHALL, for a sub-word store, update only the addressed lanes from writeData_in[7:0] or [15:0].
REQ-027 SHALL, for a sub-word load, right-justify the lane and sign-extend when signed_in = 1, else zero-extend.
REQ-028 SHALL, for a store, drive data_out = 0 in RESP.

Reset
REQ-029 SHALL, while reset_in is high at an edge, force state IDLE, counter 0, ready_out 1, done_out 0, err_out 0 and data_out 0.
REQ-030 SHALL let reset mid-access abort it: a store still in BUSY is never committed and no done_out is issued.
REQ-031 SHALL NOT clear memory contents on reset.

Configuration
REQ-032 SHALL support macro DMEM_SUBWORD_EN: when defined, byte and half accesses behave per REQ-025..027.
REQ-033 SHALL, when DMEM_SUBWORD_EN is undefined, treat every size_in value other than 10 as a fault, and SHALL compile no lane-merge or extension logic.

Verification
REQ-034 SHALL cover: LATENCY = 2; store word 32'hDEADBEEF to 0x10000004 and then load it -> done_out 3 cycles after each accept, load data_out = 32'hDEADBEEF, err_out = 0.
REQ-035 SHALL cover (SUBWORD_EN): store byte 8'h80 to 0x10000009, then signed load byte at 0x10000009 -> 32'hFFFFFF80; unsigned load -> 32'h00000080; word load at 0x10000008 -> bits [15:8] = 8'h80, other lanes unchanged.
REQ-036 SHALL cover: load word at 0x10000080 (DEPTH_WORDS = 32), load at 0x0FFFFFFC, and load word at 0x10000002 -> each returns err_out = 1 with data_out = 0, memory unchanged.
REQ-037 SHALL cover: req_in held high continuously for 10 accesses -> ready_out low from accept to RESP, exactly one done_out per access, no request dropped or duplicated.
REQ-038 SHALL cover: reset_in pulsed in the first BUSY cycle of a store of 32'h12345678 to 0x10000000 -> no done_out, a subsequent load returns the prior contents, ready_out = 1 in the cycle after reset.
